// File: rtl/cpu_control_unit_pkg.sv
// Shared encodings for the PIC10-style control unit: opcode fields, SFR map,
// PC mux selects, FSM states and the decoded instruction class bundle.
package cpu_control_unit_pkg;

    localparam int unsigned INSTR_W = 12;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned PCSEL_W = 2;
    localparam int unsigned PHASE_W = 2;

    // Opcode fields, named by how many top bits of the instruction they cover
    localparam logic [6:0] OP7_MISC   = 7'b0000000;
    localparam logic [6:0] OP7_MOVWF  = 7'b0000001;
    localparam logic [6:0] OP7_CLRW   = 7'b0000010;
    localparam logic [5:0] OP6_DECFSZ = 6'b001011;
    localparam logic [5:0] OP6_INCFSZ = 6'b001111;
    localparam logic [3:0] OP4_BTFSC  = 4'b0110;
    localparam logic [3:0] OP4_BTFSS  = 4'b0111;
    localparam logic [3:0] OP4_RETLW  = 4'b1000;
    localparam logic [3:0] OP4_CALL   = 4'b1001;
    localparam logic [2:0] OP3_GOTO   = 3'b101;
    localparam logic [1:0] OP2_BYTE   = 2'b00;
    localparam logic [1:0] OP2_BIT    = 2'b01;
    localparam logic [1:0] OP2_LIT    = 2'b11;

    localparam logic [INSTR_W-1:0] INSTR_SLEEP = 12'h003;
    localparam logic [2:0]         TRIS_F_MIN  = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_INDF     = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_TMR0     = 5'd1;
    localparam logic [ADDR_W-1:0] ADDR_PCL      = 5'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 5'd3;
    localparam logic [ADDR_W-1:0] ADDR_FSR      = 5'd4;
    localparam logic [ADDR_W-1:0] ADDR_GPIO0    = 5'd5;
    localparam logic [ADDR_W-1:0] ADDR_GPIO1    = 5'd6;
    localparam logic [ADDR_W-1:0] ADDR_GPIO2    = 5'd7;
    localparam logic [ADDR_W-1:0] ADDR_RAM_BASE = 5'd8;

    localparam logic [PCSEL_W-1:0] PCSEL_GOTO  = 2'b00;
    localparam logic [PCSEL_W-1:0] PCSEL_CALL  = 2'b01;
    localparam logic [PCSEL_W-1:0] PCSEL_STACK = 2'b10;
    localparam logic [PCSEL_W-1:0] PCSEL_ALU   = 2'b11;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_Q1    = 3'd1,
        ST_Q2    = 3'd2,
        ST_Q3    = 3'd3,
        ST_Q4    = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    typedef struct packed {
        logic literal;
        logic file_byte;
        logic bit_op;
        logic skip_type;
        logic skip_if_clear;
        logic goto_op;
        logic call_op;
        logic retlw_op;
        logic tris_op;
        logic sleep_op;
        logic dest_w;
        logic indf;
    } decode_t;

    function automatic logic is_ram_addr(input logic [ADDR_W-1:0] addr);
        return addr >= ADDR_RAM_BASE;
    endfunction

endpackage

// File: rtl/cpu_control_unit_decoder.sv
// Combinational classifier for the 12-bit baseline instruction word.
module cpu_instruction_decoder
    import cpu_control_unit_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output decode_t            o_dec
);

    logic [6:0]        w_op7;
    logic [5:0]        w_op6;
    logic [3:0]        w_op4;
    logic [2:0]        w_op3;
    logic [1:0]        w_op2;
    logic              w_d;
    logic [ADDR_W-1:0] w_f;
    logic              w_file_access;

    assign w_op7 = i_instr[11:5];
    assign w_op6 = i_instr[11:6];
    assign w_op4 = i_instr[11:8];
    assign w_op3 = i_instr[11:9];
    assign w_op2 = i_instr[11:10];
    assign w_d   = i_instr[5];
    assign w_f   = i_instr[4:0];

    always_comb begin
        o_dec         = '0;
        w_file_access = 1'b0;

        o_dec.literal   = (w_op2 == OP2_LIT);
        o_dec.file_byte = ((w_op2 == OP2_BYTE) && (w_op6 != 6'd0)) || (w_op7 == OP7_MOVWF);
        o_dec.bit_op    = (w_op2 == OP2_BIT);
        o_dec.skip_type = (w_op6 == OP6_DECFSZ) || (w_op6 == OP6_INCFSZ)
                       || (w_op4 == OP4_BTFSC)  || (w_op4 == OP4_BTFSS);
        o_dec.skip_if_clear = (w_op4 == OP4_BTFSS);
        o_dec.goto_op   = (w_op3 == OP3_GOTO);
        o_dec.call_op   = (w_op4 == OP4_CALL);
        o_dec.retlw_op  = (w_op4 == OP4_RETLW);
        o_dec.tris_op   = (w_op7 == OP7_MISC) && (i_instr[4:3] == 2'b00)
                       && (i_instr[2:0] >= TRIS_F_MIN);
        o_dec.sleep_op  = (i_instr == INSTR_SLEEP);
        o_dec.dest_w    = o_dec.literal | o_dec.retlw_op | (o_dec.file_byte & ~w_d);

        // CLRW shares the byte-op row but has no file operand
        w_file_access = (o_dec.file_byte | o_dec.bit_op) & (w_op7 != OP7_CLRW);
        o_dec.indf    = w_file_access && (w_f == ADDR_INDF);
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Q1..Q4 instruction sequencer for the PIC10-compatible core; drives every
// datapath strobe from the current phase and the decoded instruction.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES = 2,
    parameter bit          HALT_ON_SLEEP  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction_reg_out,
    input  logic [ADDR_W-1:0]  reg_address,
    input  logic               zero_result,
    output logic               store_alu_w,
    output logic               alu_in_select,
    output logic               load_status_reg,
    output logic               skip_next_instruction,
    output logic               load_instruction_reg,
    output logic [PCSEL_W-1:0] pc_mux_select,
    output logic               load_pc,
    output logic               inc_pc,
    output logic               inc_stack,
    output logic               dec_stack,
    output logic               load_stack,
    output logic               load_fsr,
    output logic               reg_address_mux_select,
    output logic               load_ram,
    output logic               load_tris0,
    output logic               load_tris1,
    output logic               load_tris2,
    output logic               load_gpio0,
    output logic               load_gpio1,
    output logic               load_gpio2,
    output logic [PHASE_W-1:0] q_phase,
    output logic               halted
);

    localparam int unsigned CNT_W = $clog2(STARTUP_CYCLES + 2);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_startup_cnt;
    logic             r_skip_pending;
    logic             r_squash;
    decode_t          w_dec;
    logic             w_startup_done;
    logic             w_file_write;
    logic             w_skip_hit;

    cpu_instruction_decoder u_decoder (
        .i_instr (instruction_reg_out),
        .o_dec   (w_dec)
    );

    assign w_startup_done = (32'(r_startup_cnt) + 32'd1) >= STARTUP_CYCLES;
    assign w_file_write   = (w_dec.file_byte & ~w_dec.dest_w) | (w_dec.bit_op & ~w_dec.skip_type);
    assign w_skip_hit     = w_dec.skip_type & (zero_result ^ w_dec.skip_if_clear);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_squash marks the instruction fetched under a pending skip so its
    // strobes (including any skip of its own) are suppressed for Q2..Q4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_startup_cnt  <= '0;
            r_skip_pending <= 1'b0;
            r_squash       <= 1'b0;
        end else begin
            if (r_state == ST_RESET) begin
                r_startup_cnt <= r_startup_cnt + CNT_W'(1);
            end
            if (r_state == ST_Q1) begin
                r_squash       <= r_skip_pending;
                r_skip_pending <= 1'b0;
            end
            if ((r_state == ST_Q4) && !r_squash && w_skip_hit) begin
                r_skip_pending <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET: if (w_startup_done) w_next_state = ST_Q1;
            ST_Q1:    w_next_state = ST_Q2;
            ST_Q2:    w_next_state = ST_Q3;
            ST_Q3:    w_next_state = ST_Q4;
            ST_Q4: begin
                if (HALT_ON_SLEEP && w_dec.sleep_op && !r_squash) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_Q1;
                end
            end
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_RESET;
        endcase
    end

    // Strobe decode from phase and instruction class
    always_comb begin
        store_alu_w            = 1'b0;
        alu_in_select          = 1'b0;
        load_status_reg        = 1'b0;
        skip_next_instruction  = 1'b0;
        load_instruction_reg   = 1'b0;
        pc_mux_select          = PCSEL_GOTO;
        load_pc                = 1'b0;
        inc_pc                 = 1'b0;
        inc_stack              = 1'b0;
        dec_stack              = 1'b0;
        load_stack             = 1'b0;
        load_fsr               = 1'b0;
        reg_address_mux_select = 1'b0;
        load_ram               = 1'b0;
        load_tris0             = 1'b0;
        load_tris1             = 1'b0;
        load_tris2             = 1'b0;
        load_gpio0             = 1'b0;
        load_gpio1             = 1'b0;
        load_gpio2             = 1'b0;
        q_phase                = 2'd0;
        halted                 = 1'b0;

        case (r_state)
            ST_Q1: begin
                load_instruction_reg  = 1'b1;
                inc_pc                = 1'b1;
                skip_next_instruction = r_skip_pending;
            end
            ST_Q2: begin
                q_phase                = 2'd1;
                reg_address_mux_select = w_dec.indf & ~r_squash;
            end
            ST_Q3: begin
                q_phase = 2'd2;
                if (!r_squash) begin
                    reg_address_mux_select = w_dec.indf;
                    alu_in_select          = w_dec.literal | w_dec.retlw_op;
                    store_alu_w            = w_dec.dest_w;
                    if (w_file_write) begin
                        if (is_ram_addr(reg_address)) begin
                            load_ram = 1'b1;
                        end else begin
                            case (reg_address)
                                ADDR_PCL: begin
                                    load_pc       = 1'b1;
                                    pc_mux_select = PCSEL_ALU;
                                end
                                ADDR_STATUS:           load_status_reg = 1'b1;
                                ADDR_FSR:              load_fsr        = 1'b1;
                                ADDR_GPIO0:            load_gpio0      = 1'b1;
                                ADDR_GPIO1:            load_gpio1      = 1'b1;
                                ADDR_GPIO2:            load_gpio2      = 1'b1;
                                ADDR_INDF, ADDR_TMR0:  ;
                                default:               ;
                            endcase
                        end
                    end
                    if (w_dec.tris_op) begin
                        case (instruction_reg_out[2:0])
                            3'd5:    load_tris0 = 1'b1;
                            3'd6:    load_tris1 = 1'b1;
                            3'd7:    load_tris2 = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            ST_Q4: begin
                q_phase = 2'd3;
                if (!r_squash) begin
                    if (w_dec.goto_op) begin
                        load_pc       = 1'b1;
                        pc_mux_select = PCSEL_GOTO;
                    end else if (w_dec.call_op) begin
                        load_stack    = 1'b1;
                        inc_stack     = 1'b1;
                        load_pc       = 1'b1;
                        pc_mux_select = PCSEL_CALL;
                    end else if (w_dec.retlw_op) begin
                        dec_stack     = 1'b1;
                        load_pc       = 1'b1;
                        pc_mux_select = PCSEL_STACK;
                    end
                end
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: stimulus queues the expected strobe
// vector for each clock, a negedge monitor pops and compares.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] instruction_reg_out = 12'h000;
    logic [4:0]  reg_address = 5'd0;
    logic        zero_result = 1'b0;

    logic       store_alu_w, alu_in_select, load_status_reg, skip_next_instruction;
    logic       load_instruction_reg, load_pc, inc_pc, inc_stack, dec_stack, load_stack;
    logic       load_fsr, reg_address_mux_select, load_ram;
    logic       load_tris0, load_tris1, load_tris2, load_gpio0, load_gpio1, load_gpio2;
    logic [1:0] pc_mux_select, q_phase;
    logic       halted;

    localparam int unsigned TIMEOUT_CYCLES = 2000;

    // Observed vector layout (bit 0 upward)
    localparam logic [23:0] STW   = 24'h000001;
    localparam logic [23:0] ALUI  = 24'h000002;
    localparam logic [23:0] LDST  = 24'h000004;
    localparam logic [23:0] SKIP  = 24'h000008;
    localparam logic [23:0] LDIR  = 24'h000010;
    localparam logic [23:0] SEL01 = 24'h000020;
    localparam logic [23:0] SEL10 = 24'h000040;
    localparam logic [23:0] SEL11 = 24'h000060;
    localparam logic [23:0] LDPC  = 24'h000080;
    localparam logic [23:0] INCPC = 24'h000100;
    localparam logic [23:0] INCS  = 24'h000200;
    localparam logic [23:0] DECS  = 24'h000400;
    localparam logic [23:0] LDSTK = 24'h000800;
    localparam logic [23:0] LDFSR = 24'h001000;
    localparam logic [23:0] RAMX  = 24'h002000;
    localparam logic [23:0] LDRAM = 24'h004000;
    localparam logic [23:0] TRIS0 = 24'h008000;
    localparam logic [23:0] TRIS1 = 24'h010000;
    localparam logic [23:0] TRIS2 = 24'h020000;
    localparam logic [23:0] GPIO0 = 24'h040000;
    localparam logic [23:0] GPIO1 = 24'h080000;
    localparam logic [23:0] GPIO2 = 24'h100000;
    localparam logic [23:0] PQ2   = 24'h200000;
    localparam logic [23:0] PQ3   = 24'h400000;
    localparam logic [23:0] PQ4   = 24'h600000;
    localparam logic [23:0] HALT  = 24'h800000;
    localparam logic [23:0] FETCH = LDIR | INCPC;

    typedef struct {
        string       tag;
        logic [23:0] vec;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] w_obs;

    cpu_control_unit #(.STARTUP_CYCLES(2), .HALT_ON_SLEEP(1'b1)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .instruction_reg_out    (instruction_reg_out),
        .reg_address            (reg_address),
        .zero_result            (zero_result),
        .store_alu_w            (store_alu_w),
        .alu_in_select          (alu_in_select),
        .load_status_reg        (load_status_reg),
        .skip_next_instruction  (skip_next_instruction),
        .load_instruction_reg   (load_instruction_reg),
        .pc_mux_select          (pc_mux_select),
        .load_pc                (load_pc),
        .inc_pc                 (inc_pc),
        .inc_stack              (inc_stack),
        .dec_stack              (dec_stack),
        .load_stack             (load_stack),
        .load_fsr               (load_fsr),
        .reg_address_mux_select (reg_address_mux_select),
        .load_ram               (load_ram),
        .load_tris0             (load_tris0),
        .load_tris1             (load_tris1),
        .load_tris2             (load_tris2),
        .load_gpio0             (load_gpio0),
        .load_gpio1             (load_gpio1),
        .load_gpio2             (load_gpio2),
        .q_phase                (q_phase),
        .halted                 (halted)
    );

    assign w_obs = {halted, q_phase, load_gpio2, load_gpio1, load_gpio0,
                    load_tris2, load_tris1, load_tris0, load_ram, reg_address_mux_select,
                    load_fsr, load_stack, dec_stack, inc_stack, inc_pc, load_pc,
                    pc_mux_select, load_instruction_reg, skip_next_instruction,
                    load_status_reg, alu_in_select, store_alu_w};

    always #5 clk = ~clk;

    // Monitor: one expected vector per clock, sampled on the falling edge
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            if (w_obs !== mon_e.vec) begin
                n_fail++;
                $display("FAIL %s: got %06h expected %06h", mon_e.tag, w_obs, mon_e.vec);
            end
        end
    end

    // Watchdog: the sequence must finish within a bounded number of clocks
    initial begin
        repeat (TIMEOUT_CYCLES) @(posedge clk);
        n_fail++;
        $display("FAIL timeout: wait expired after %0d clocks", TIMEOUT_CYCLES);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic cyc(input logic r, input logic [11:0] ins, input logic z,
                       input logic [4:0] ra, input logic [23:0] v, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = r;
        instruction_reg_out = ins;
        zero_result         = z;
        reg_address         = ra;
        e.tag = tag;
        e.vec = v;
        sb_q.push_back(e);
    endtask

    task automatic run(input logic [11:0] ins, input logic z, input logic [4:0] ra,
                       input logic [23:0] x1, input logic [23:0] x2,
                       input logic [23:0] x3, input logic [23:0] x4, input string tag);
        cyc(1'b0, ins, z, ra, FETCH | x1, {tag, "_q1"});
        cyc(1'b0, ins, z, ra, PQ2 | x2,   {tag, "_q2"});
        cyc(1'b0, ins, z, ra, PQ3 | x3,   {tag, "_q3"});
        cyc(1'b0, ins, z, ra, PQ4 | x4,   {tag, "_q4"});
    endtask

    initial begin
        cyc(1'b1, 12'h000, 1'b0, 5'd0, 24'h0, "rst_hold0");
        #1;
        n_tests++;
        if (w_obs !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %06h expected 000000", w_obs);
        end
        cyc(1'b1, 12'h000, 1'b0, 5'd0, 24'h0, "rst_hold1");
        cyc(1'b0, 12'h000, 1'b0, 5'd0, 24'h0, "startup0");
        cyc(1'b0, 12'h000, 1'b0, 5'd0, 24'h0, "startup1");

        run(12'hC5A, 1'b0, 5'h1A, 0, 0, ALUI | STW, 0, "movlw");
        run(12'h030, 1'b0, 5'h10, 0, 0, LDRAM, 0, "movwf_ram");
        run(12'h026, 1'b0, 5'h06, 0, 0, GPIO1, 0, "movwf_gpio1");
        run(12'h020, 1'b0, 5'h12, 0, RAMX, RAMX | LDRAM, 0, "movwf_indf");
        run(12'h940, 1'b0, 5'h02, 0, 0, 0, LDSTK | INCS | LDPC | SEL01, "call");
        run(12'h807, 1'b0, 5'h02, 0, 0, ALUI | STW, DECS | LDPC | SEL10, "retlw");
        run(12'hAA5, 1'b0, 5'h02, 0, 0, 0, LDPC, "goto");
        run(12'h022, 1'b0, 5'h02, 0, 0, LDPC | SEL11, 0, "movwf_pcl");
        run(12'h023, 1'b0, 5'h03, 0, 0, LDST, 0, "movwf_status");
        run(12'h024, 1'b0, 5'h04, 0, 0, LDFSR, 0, "movwf_fsr");
        run(12'h027, 1'b0, 5'h07, 0, 0, GPIO2, 0, "movwf_gpio2");
        run(12'h021, 1'b0, 5'h01, 0, 0, 0, 0, "movwf_tmr0");
        run(12'h1D0, 1'b0, 5'h10, 0, 0, STW, 0, "addwf_to_w");
        run(12'h005, 1'b0, 5'h05, 0, 0, TRIS0, 0, "tris5");
        run(12'h006, 1'b0, 5'h06, 0, 0, TRIS1, 0, "tris6");
        run(12'h570, 1'b0, 5'h10, 0, 0, LDRAM, 0, "bsf");

        run(12'h2F0, 1'b1, 5'h10, 0, 0, LDRAM, 0, "decfsz_z1");
        run(12'hC11, 1'b0, 5'h10, SKIP, 0, 0, 0, "skipped_movlw");
        run(12'h2F0, 1'b0, 5'h10, 0, 0, LDRAM, 0, "decfsz_z0");
        run(12'hC11, 1'b0, 5'h10, 0, 0, ALUI | STW, 0, "movlw_not_skipped");
        run(12'h710, 1'b0, 5'h10, 0, 0, 0, 0, "btfss_z0");
        run(12'h610, 1'b1, 5'h10, SKIP, 0, 0, 0, "squashed_btfsc");
        run(12'h1C0, 1'b0, 5'h12, 0, RAMX, RAMX | STW, 0, "no_cascade_addwf_indf");
        run(12'h610, 1'b1, 5'h10, 0, 0, 0, 0, "btfsc_z1");
        run(12'h030, 1'b0, 5'h10, SKIP, 0, 0, 0, "skipped_movwf");
        run(12'h004, 1'b0, 5'h10, 0, 0, 0, 0, "clrwdt");
        run(12'h002, 1'b0, 5'h10, 0, 0, 0, 0, "option");
        run(12'h001, 1'b0, 5'h10, 0, 0, 0, 0, "undefined");

        cyc(1'b0, 12'h1F0, 1'b0, 5'h10, FETCH, "addwf_f_q1");
        cyc(1'b0, 12'h1F0, 1'b0, 5'h10, PQ2,   "addwf_f_q2");
        cyc(1'b1, 12'h1F0, 1'b0, 5'h10, 24'h0, "rst_mid_q3");
        cyc(1'b1, 12'h1F0, 1'b0, 5'h10, 24'h0, "rst_mid_hold");
        cyc(1'b0, 12'h1F0, 1'b0, 5'h10, 24'h0, "restart0");
        cyc(1'b0, 12'h1F0, 1'b0, 5'h10, 24'h0, "restart1");
        run(12'h1F0, 1'b0, 5'h10, 0, 0, LDRAM, 0, "addwf_f_after_rst");

        run(12'h003, 1'b0, 5'h10, 0, 0, 0, 0, "sleep");
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 12'h003, 1'b0, 5'h10, HALT, "halt_hold");
        end
        cyc(1'b1, 12'h003, 1'b0, 5'h10, 24'h0, "rst_in_halt");
        cyc(1'b0, 12'hC5A, 1'b0, 5'h10, 24'h0, "halt_restart0");
        cyc(1'b0, 12'hC5A, 1'b0, 5'h10, 24'h0, "halt_restart1");
        run(12'hC5A, 1'b0, 5'h10, 0, 0, ALUI | STW, 0, "movlw_after_halt");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d expected vectors never compared", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Instruction-sequencing FSM for the PIC10-compatible core; drives every control input of cpu_datapath.
- Runs PIC-style 4-phase instruction cycles (Q1..Q4) and decodes the 12-bit baseline opcode.
- Handles skip (NOP insertion), CALL/RETLW stack sequencing, PCL writes, indirect addressing, TRIS, and SLEEP halt.
- Sits beside cpu_datapath in the core top level and takes instruction_reg_out, reg_address and zero_result back from it.

Parameters:
- STARTUP_CYCLES, 2, idle clocks in RESET state after rst deasserts, before the first Q1.
- HALT_ON_SLEEP, 1, 1: SLEEP halts until rst. 0: SLEEP executes as NOP.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- instruction_reg_out  in  12  current instruction from the datapath.
- reg_address  in  5  effective file address after the FSR mux.
- zero_result  in  1  STATUS.Z; valid in Q4.
- store_alu_w, alu_in_select, load_status_reg, skip_next_instruction, load_instruction_reg  out  1 each.
- pc_mux_select  out  2  00 GOTO k[8:0]; 01 CALL {0,k[7:0]}; 10 stack top; 11 ALU output.
- load_pc, inc_pc, inc_stack, dec_stack, load_stack, load_fsr, reg_address_mux_select, load_ram  out  1 each.
- load_tris0..2, load_gpio0..2  out  1 each.
- q_phase  out  2  current phase: 0=Q1 .. 3=Q4.
- halted  out  1  high in HALT state.

Behaviour:
- States: RESET, Q1, Q2, Q3, Q4, HALT.
- rst asserted: state goes to RESET, skip_pending=0, startup counter cleared, every output 0, q_phase=0.
- RESET counts STARTUP_CYCLES clocks, then goes to Q1.
- Main loop: Q1 -> Q2 -> Q3 -> Q4 -> Q1. One instruction per 4 clocks.
- All outputs are decoded from state and instruction_reg_out. Every load/inc/dec is a single-clock pulse.
- Q1:
  - load_instruction_reg=1 and inc_pc=1.
  - If skip_pending=1: also skip_next_instruction=1 (the datapath loads a NOP), then clear skip_pending.
- Q2 (decode):
  - reg_address_mux_select=1 when a file-format instruction has f==0 (INDF).
  - That value is held through Q3. Otherwise 0.
- Q3 (execute / writeback):
  - alu_in_select=1 for literal ops (RETLW, MOVLW, IORLW, ANDLW, XORLW); 0 for file ops.
  - Destination W (d=0 byte ops, literal ops, RETLW): store_alu_w=1.
  - Destination file (d=1, MOVWF, CLRF, BCF, BSF): write strobe decoded from reg_address:
    - 2 -> load_pc=1 with pc_mux_select=11.
    - 3 -> load_status_reg.
    - 4 -> load_fsr.
    - 5/6/7 -> load_gpio0/1/2.
    - 8..31 -> load_ram.
    - 0 or 1 -> no strobe.
  - TRIS f with f=5/6/7 -> load_tris0/1/2. Other TRIS f values act as NOP.
- Q4 (control flow):
  - GOTO: load_pc=1, sel 00.
  - CALL: load_stack=1, inc_stack=1, load_pc=1, sel 01, all in the same clock.
  - RETLW: dec_stack=1, load_pc=1, sel 10.
  - DECFSZ/INCFSZ: set skip_pending if zero_result=1.
  - BTFSC: set skip_pending if zero_result=1.
  - BTFSS: set skip_pending if zero_result=0.
- A skipped instruction costs a full 4-clock cycle, giving 2-cycle skip timing.
- A skip instruction that is itself being NOPed never sets skip_pending, so chained skips do not cascade.
- SLEEP with HALT_ON_SLEEP=1: Q4 -> HALT. HALT holds all outputs 0 and halted=1, and exits only via rst.
- OPTION, CLRWDT and undefined opcodes execute as NOP: no strobes except the Q1 fetch.
- rst mid-cycle: the state machine aborts immediately and no pulse is completed. PC and stack reset inside the datapath.

Decomposition:
- definition.vh gains:
  - opcode field constants;
  - SFR address constants (INDF=0, TMR0=1, PCL=2, STATUS=3, FSR=4, GPIO0..2=5..7, RAM_BASE=8);
  - pc_mux_select encodings;
  - state encodings.
- One combinational sub-module, cpu_instruction_decoder: instruction in; one-hot class flags out (literal, file_byte, bit_op, skip_type, goto, call, retlw, tris, sleep, dest_w).
- cpu_control_unit keeps the FSM, skip_pending, the startup counter, and strobe generation.

Test Plan:
- rst released, STARTUP_CYCLES=2 -> 2 idle clocks, then Q1 with load_instruction_reg=1 and inc_pc=1. All outputs 0 during rst.
- MOVLW 0x5A (0xC5A) -> Q3: alu_in_select=1, store_alu_w=1. No file strobe. No Q4 strobe.
- MOVWF 0x10 (0x030) -> Q3 load_ram=1. MOVWF 0x06 -> load_gpio1=1. MOVWF 0x00 with FSR=0x12 -> reg_address_mux_select=1 in Q2–Q3, load_ram=1.
- CALL 0x40 (0x940), then RETLW 0x07 -> CALL Q4: load_stack, inc_stack, load_pc, sel 01 in the same clock. RETLW: Q3 store_alu_w with literal, Q4 dec_stack, load_pc, sel 10.
- DECFSZ 0x10,1 with zero_result=1 -> next Q1 asserts skip_next_instruction. Repeat with zero_result=0 -> no skip. BTFSS with zero_result=0 -> skip.
- SLEEP (0x003) -> halted=1 after Q4 with all strobes 0 for 20 clocks. Async rst pulse during HALT, and during Q3 of ADDWF -> outputs drop to 0 immediately, then restart.
